// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues in-order imem requests from pc and pairs each returned word with its address.
// Latency: response registered into its slot, visible on out_* the cycle after it arrives; pc_next is combinational.
// Backpressure: requests stop while slots + pending discards fill DEPTH; out_* holds while decode stalls.
module fetch_stage #(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic [31:0] pc_next,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

   typedef logic [AW:0]   ptr_t;
   typedef logic [AW-1:0] idx_t;

   // Pointers wrap naturally; the extra MSB distinguishes full from empty.
   ptr_t head_q, head_d;
   ptr_t tail_q, tail_d;
   // Oldest unfilled slot: responses return in order, so fills advance like a third pointer.
   ptr_t fill_q, fill_d;
   // Responses still owed by memory for requests that were flushed.
   ptr_t drop_q, drop_d;

   logic [DEPTH-1:0] filled_q, filled_d;
   logic [31:0]      slot_pc_q    [DEPTH];
   logic [31:0]      slot_instr_q [DEPTH];

   ptr_t        used;
   ptr_t        unfilled;
   logic [AW+1:0] occupancy;
   idx_t        head_idx;
   idx_t        tail_idx;
   idx_t        fill_idx;
   logic        alloc;
   logic        pop;
   logic        rsp_keep;
   logic        rsp_discard;
   logic        head_filled;

   assign head_idx  = head_q[AW-1:0];
   assign tail_idx  = tail_q[AW-1:0];
   assign fill_idx  = fill_q[AW-1:0];
   assign used      = tail_q - head_q;
   assign unfilled  = tail_q - fill_q;
   assign occupancy = {1'b0, used} + {1'b0, drop_q};

   // Handshake qualification: gating looks only at registered state, so a pop never frees a slot for a same-cycle alloc.
   always_comb begin
      head_filled    = filled_q[head_idx];
      imem_req_valid = rst && !redirect_valid && (occupancy < DEPTH_W);
      alloc          = imem_req_valid && imem_req_ready;
      out_valid      = rst && head_filled && !redirect_valid;
      pop            = out_valid && out_ready;
      rsp_discard    = imem_rsp_valid && (drop_q != '0);
      rsp_keep       = imem_rsp_valid && !redirect_valid && (drop_q == '0) && (fill_q != tail_q);
   end

   // Request address and decode-side payload; payload forced to zero while in reset.
   always_comb begin
      imem_addr = {pc[31:2], 2'b00};
      out_pc    = '0;
      out_instr = '0;
      if (rst) begin
         out_pc    = slot_pc_q[head_idx];
         out_instr = slot_instr_q[head_idx];
      end
   end

   // Next PC: redirect wins, then advance on an accepted request, otherwise hold.
   always_comb begin
      pc_next = pc;
      if (redirect_valid) begin
         pc_next = redirect_pc;
      end else if (alloc) begin
         pc_next = pc + 32'd4;
      end
   end

   // Pointer, discard-count and filled-flag next state; a redirect empties every slot.
   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      fill_d   = fill_q;
      drop_d   = drop_q;
      filled_d = filled_q;
      if (redirect_valid) begin
         head_d   = tail_q;
         fill_d   = tail_q;
         filled_d = '0;
         // Every unfilled slot still owes a response; one arriving now is already discarded.
         if (imem_rsp_valid && ((drop_q + unfilled) != '0)) begin
            drop_d = drop_q + unfilled - ptr_t'(1);
         end else begin
            drop_d = drop_q + unfilled;
         end
      end else begin
         if (alloc) begin
            tail_d             = tail_q + ptr_t'(1);
            filled_d[tail_idx] = 1'b0;
         end
         if (rsp_keep) begin
            fill_d             = fill_q + ptr_t'(1);
            filled_d[fill_idx] = 1'b1;
         end
         if (pop) begin
            head_d             = head_q + ptr_t'(1);
            filled_d[head_idx] = 1'b0;
         end
         if (rsp_discard) begin
            drop_d = drop_q - ptr_t'(1);
         end
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q   <= '0;
         tail_q   <= '0;
         fill_q   <= '0;
         drop_q   <= '0;
         filled_q <= '0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         fill_q   <= fill_d;
         drop_q   <= drop_d;
         filled_q <= filled_d;
      end
   end

   // Slot payload: pc captured at alloc into the tail slot, instruction captured at fill.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_pc_q[i]    <= '0;
            slot_instr_q[i] <= '0;
         end
      end else begin
         if (alloc) begin
            slot_pc_q[tail_idx] <= pc;
         end
         if (rsp_keep) begin
            slot_instr_q[fill_idx] <= imem_rdata;
         end
      end
   end

endmodule
